timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Button front end for the stopwatch: synchronises and debounces the raw start/stop and clear push-buttons and runs the run/hold state machine. It drives the stopwatch's `pause` input and its clear input, so the timer is operated from two physical buttons instead of level switches. It also exposes the current mode for status LEDs.

## Interface

Parameters:
- `DB_CNT`, default 20000: consecutive cycles a synchronised button level must differ from the debounced level before it is accepted. Legal range is ≥1. Benches use 4.

Ports:
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `btn_ss_raw` input 1: raw start/stop button. Active-high and asynchronous.
- `btn_clr_raw` input 1: raw clear button. Active-high and asynchronous.
- `pause` output 1: high means the stopwatch is frozen. Drives the timer's pause input.
- `clr` output 1: one-cycle active-high clear pulse. Drives the timer's clear input.
- `mode` output 2: current state code. `2'b00` = IDLE, `2'b01` = RUN, `2'b10` = HOLD.

## Operation

Each button path:
- Two-flop synchroniser gives `sync2`.
- Debounced level `stable` (reset 0) and counter `cnt` (reset 0, width $clog2(DB_CNT+1)).
- Edge rule: if `sync2 == stable`, then `cnt <= 0`. Otherwise `cnt <= cnt+1`. When `cnt == DB_CNT-1`, set `stable <= sync2` and `cnt <= 0`.
- `stable_d` is `stable` delayed one cycle.
- Press event `evt = stable & ~stable_d`, combinational. Releases generate no event.

FSM (reset state IDLE):
- IDLE: `ss_evt` goes to RUN.
- RUN: `ss_evt` goes to HOLD.
- HOLD: `ss_evt` goes to RUN.
- Any state: `clr_evt` goes to IDLE and sets `clr <= 1` for the next cycle. This includes IDLE, which still pulses `clr`.
- Both events in the same cycle: clear wins. The next state is IDLE, `clr` pulses, and `ss_evt` is discarded.
- Holding a button produces exactly one event. A glitch shorter than DB_CNT cycles after synchronisation produces none.

Outputs:
- `pause = (state != RUN)`, decoded from the state register.
- `mode` is the state register.
- `clr` is a register, high for exactly one cycle per `clr_evt`.

## Timing

- Reset values: `pause=1`, `clr=0`, `mode=2'b00`. All synchroniser, counter, stable and stable_d flops are 0.
- Latency: raw rise sampled at edge E0, `sync2` high after E1, `stable` high after E1+DB_CNT.
  - `state` and `clr` update at edge E2+DB_CNT, i.e. DB_CNT+2 edges after the sampling edge.
  - For DB_CNT=4: 6 edges.
- `clr` falls at the following edge unless another `clr_evt` occurs. It cannot, because a new event requires a release plus a re-press.
- `rst_n` asserted mid-debounce or mid-pulse: everything clears immediately, asynchronously.
  - A button held through reset release becomes `stable` after the normal debounce delay.
  - It therefore generates one press event after reset.
- Counter wrap is impossible: it is cleared at DB_CNT-1.

## Structure

- Shared package `timer_pkg`: state encoding constants `ST_IDLE=2'b00`, `ST_RUN=2'b01`, `ST_HOLD=2'b10`.
- Sub-module `btn_debounce` (parameter DB_CNT; ports `clk`, `rst_n`, `btn_raw`, `level`, `press`), instantiated twice.
- The FSM and `clr` register live in `timer_ctrl`.
- At the top level, `timer_ctrl.pause` feeds the timer's pause input.
- `clr` is OR-ed into the timer's clear input alongside the existing reset.

## Test plan

All scenarios use DB_CNT=4.
- Reset: hold `rst_n=0` for 3 cycles, then release. Expect `pause=1`, `clr=0`, `mode=00` throughout and after.
- Start: raise `btn_ss_raw` and hold 20 cycles. Expect `mode=01` and `pause=0` exactly 6 edges after the sampling edge, and no further change while held. Release, then press again: expect `mode=10`, `pause=1`. Press a third time: expect `mode=01`.
- Bounce: toggle `btn_ss_raw` with high pulses of 1, 2 and 3 cycles separated by 1-cycle lows, then hold high. Expect exactly one transition, 6 edges after the final rise. Expect no event from the short pulses.
- Clear: from RUN, press `btn_clr_raw`. Expect `clr=1` for exactly one cycle, `mode=00` and `pause=1` on the same edge. Pressing clear again in IDLE gives another 1-cycle `clr`.
- Simultaneous: raise both buttons on the same edge while in HOLD. Expect `mode=00`, a single `clr` pulse, and no RUN state at any time.
- Mid-operation reset: pulse `rst_n` low for 1 cycle while in RUN with `btn_ss_raw` held.
  - Expect `mode=00` and `pause=1` immediately.
  - Then expect one press event, giving `mode=01`, after DB_CNT+2 edges, then no further change.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch button front end.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Button-side and timer-side signals of the stopwatch front end.
interface timer_ctrl_if;

  logic       btn_ss_raw;
  logic       btn_clr_raw;
  logic       pause;
  logic       clr;
  logic [1:0] mode;

  modport master (
    output btn_ss_raw,
    output btn_clr_raw,
    input  pause,
    input  clr,
    input  mode
  );

  modport slave (
    input  btn_ss_raw,
    input  btn_clr_raw,
    output pause,
    output clr,
    output mode
  );

endinterface

// File: rtl/timer_ctrl_btn_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge press detector.
module btn_debounce #(
  parameter int DB_CNT = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CNT + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        // Accepting the new level also clears the counter, so it never wraps.
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;
  assign press = stable & ~stable_d;

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch button front end: debounced start/stop and clear driving the run/hold FSM.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DB_CNT = 20000
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);

  state_t state;
  logic   clr_q;
  logic   ss_evt;
  logic   clr_evt;
  logic   ss_level;
  logic   clr_level;
  logic   unused_levels;

  btn_debounce #(.DB_CNT(DB_CNT)) u_ss_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_ss_raw),
    .level   (ss_level),
    .press   (ss_evt)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_clr_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_clr_raw),
    .level   (clr_level),
    .press   (clr_evt)
  );

  assign unused_levels = ss_level | clr_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      clr_q <= 1'b0;
    end else begin
      clr_q <= clr_evt;
      // Clear has priority; a simultaneous start/stop press is dropped.
      if (clr_evt) begin
        state <= ST_IDLE;
      end else if (ss_evt) begin
        case (state)
          ST_IDLE: state <= ST_RUN;
          ST_RUN:  state <= ST_HOLD;
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  assign bus.pause = (state != ST_RUN);
  assign bus.mode  = state;
  assign bus.clr   = clr_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with DB_CNT=4: every output change must match a queued expectation.
module tb_timer_ctrl;

  localparam int DB = 4;
  localparam int LAT = DB + 3;  // drive cycle to observed output change

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       pause;
    logic       clr;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev = '0;
  logic [1:0] exp_mode = 2'b00;
  ev_t  sb[$];

  timer_ctrl_if bus();

  timer_ctrl #(.DB_CNT(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic logic [1:0] ss_next(input logic [1:0] m);
    case (m)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  task automatic push(input int c, input logic [1:0] m, input logic cl);
    ev_t e;
    e.cyc = c; e.mode = m; e.pause = (m != 2'b01); e.clr = cl;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: any change of {mode,pause,clr} must be the next queued expectation.
  always @(negedge clk) begin
    logic [3:0] cur;
    ev_t e;
    cur = {bus.mode, bus.pause, bus.clr};
    if (mon_en && cur != prev) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {28'd0, cur}, {28'd0, prev});
      end else begin
        e = sb.pop_front();
        check("sb_cycle", cyc, e.cyc);
        check("sb_mode", {30'd0, bus.mode}, {30'd0, e.mode});
        check("sb_pause", {31'd0, bus.pause}, {31'd0, e.pause});
        check("sb_clr", {31'd0, bus.clr}, {31'd0, e.clr});
      end
    end
    prev = cur;
  end

  task automatic ss_press(input int hold);
    step(1);
    bus.btn_ss_raw = 1'b1;
    exp_mode = ss_next(exp_mode);
    push(cyc + LAT, exp_mode, 1'b0);
    step(hold);
    bus.btn_ss_raw = 1'b0;
    step(12);
  endtask

  task automatic clr_press(input logic with_ss);
    step(1);
    bus.btn_clr_raw = 1'b1;
    bus.btn_ss_raw = with_ss;
    exp_mode = 2'b00;
    push(cyc + LAT, 2'b00, 1'b1);
    push(cyc + LAT + 1, 2'b00, 1'b0);
    step(12);
    bus.btn_clr_raw = 1'b0;
    bus.btn_ss_raw = 1'b0;
    step(12);
  endtask

  task automatic drained(input string tag);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    bus.btn_ss_raw = 1'b0;
    bus.btn_clr_raw = 1'b0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_mode", {30'd0, bus.mode}, 32'd0);
      check("rst_pause", {31'd0, bus.pause}, 32'd1);
      check("rst_clr", {31'd0, bus.clr}, 32'd0);
    end
    rst_n = 1'b1;
    step(2);
    check("post_rst_mode", {30'd0, bus.mode}, 32'd0);
    check("post_rst_pause", {31'd0, bus.pause}, 32'd1);
    mon_en = 1'b1;

    // Start, hold, stop, restart
    ss_press(20);
    ss_press(10);
    ss_press(10);
    drained("sb_after_start");

    // Clear from RUN, then clear again in IDLE
    clr_press(1'b0);
    clr_press(1'b0);
    drained("sb_after_clear");

    // Bounce: 1,2,3-cycle highs with 1-cycle lows, then a real hold
    for (int unsigned w = 1; w <= 3; w++) begin
      step(1);
      bus.btn_ss_raw = 1'b1;
      step(int'(w));
      bus.btn_ss_raw = 1'b0;
    end
    ss_press(15);
    check("bounce_mode", {30'd0, bus.mode}, 32'd1);
    drained("sb_after_bounce");

    // Simultaneous press from HOLD: clear wins
    ss_press(10);
    clr_press(1'b1);
    check("simul_mode", {30'd0, bus.mode}, 32'd0);
    drained("sb_after_simul");

    // Mid-operation reset with start/stop held
    step(1);
    bus.btn_ss_raw = 1'b1;
    exp_mode = ss_next(exp_mode);
    push(cyc + LAT, exp_mode, 1'b0);
    step(12);
    check("pre_rst_mode", {30'd0, bus.mode}, 32'd1);
    push(cyc, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_mode", {30'd0, bus.mode}, 32'd0);
    check("async_rst_pause", {31'd0, bus.pause}, 32'd1);
    step(1);
    rst_n = 1'b1;
    exp_mode = 2'b01;
    push(cyc + LAT, 2'b01, 1'b0);
    step(25);
    bus.btn_ss_raw = 1'b0;
    step(15);
    check("final_mode", {30'd0, bus.mode}, 32'd1);
    drained("sb_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
